// File: rtl/sseg_pkg.sv
// sseg_pkg -- shared constants for the seven-segment scanner.
//   Segment patterns are {g,f,e,d,c,b,a}, active-low.
//   dig_t is the digit index, which is also the scan sequencer state.
package sseg_pkg;

   localparam int DIG_NUM = 4;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } dig_t;

endpackage

// File: rtl/sseg_scan_if.sv
// sseg_scan_if -- display-side signal bundle of the scanner.
//   master : drives val[15:0], dp_in[3:0], blank; observes an, seg, dp, frame_tick
//   slave  : the scanner itself (inputs/outputs reversed)
//   an, seg, dp are active-low; frame_tick is a one-cycle pulse.
interface sseg_scan_if;
   import sseg_pkg::*;

   logic [4*DIG_NUM-1:0] val;
   logic [DIG_NUM-1:0]   dp_in;
   logic                 blank;
   logic [DIG_NUM-1:0]   an;
   logic [6:0]           seg;
   logic                 dp;
   logic                 frame_tick;

   modport master (output val, dp_in, blank,
                   input  an, seg, dp, frame_tick);

   modport slave  (input  val, dp_in, blank,
                   output an, seg, dp, frame_tick);
endinterface

// File: rtl/sseg_hex_dec.sv
// sseg_hex_dec -- combinational nibble to seven-segment decoder.
//   nib : 4-bit hex digit
//   seg : {g,f,e,d,c,b,a}, active-low
module sseg_hex_dec
   import sseg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (nib)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/sseg_scan.sv
// sseg_scan -- four-digit multiplexed seven-segment display scanner.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : val/dp_in/blank in; an/seg/dp/frame_tick out (all registered)
//   DIV          : clock cycles per digit slot (2 .. 2^20)
//   DIG_N        : digit count, fixed at 4
//   Macro SSEG_LZB_EN enables leading-zero blanking of digits 1..3.
//
//   state | meaning
//   DIG0  | digit 0 (rightmost, val[3:0]) selected
//   DIG1  | digit 1 selected
//   DIG2  | digit 2 selected
//   DIG3  | digit 3 selected; its slot end is the frame boundary
module sseg_scan
   import sseg_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int DIG_N = DIG_NUM
)(
   input  logic        clk,
   input  logic        rst,
   sseg_scan_if.slave  bus
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

   logic [PW-1:0] presc;
   logic          slot_end;
   logic          frame_end;
   dig_t          idx, idx_nxt;
   logic [1:0]    dig;
   logic [15:0]   shadow_val;
   logic [3:0]    shadow_dp;
   logic [3:0]    nib;
   logic [6:0]    seg_dec;
   logic [3:0]    an_nxt;
   logic          dp_nxt;

   assign slot_end  = (presc == PW'(DIV - 1));
   assign dig       = idx;
   assign frame_end = slot_end && (dig == 2'(DIG_N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idx <= DIG0;
      else     idx <= idx_nxt;
   end

   always_comb begin
      idx_nxt = idx;
      if (slot_end) begin
         case (idx)
            DIG0:    idx_nxt = DIG1;
            DIG1:    idx_nxt = DIG2;
            DIG2:    idx_nxt = DIG3;
            DIG3:    idx_nxt = DIG0;
            default: idx_nxt = DIG0;
         endcase
      end
   end

   // Prescaler and the frame-synchronous shadow copy of the inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc      <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
      end else begin
         presc <= slot_end ? '0 : presc + PW'(1);
         if (frame_end) begin
            shadow_val <= bus.val;
            shadow_dp  <= bus.dp_in;
         end
      end
   end

   always_comb begin
      nib = shadow_val[3:0];
      case (dig)
         2'd0: nib = shadow_val[3:0];
         2'd1: nib = shadow_val[7:4];
         2'd2: nib = shadow_val[11:8];
         2'd3: nib = shadow_val[15:12];
         default: nib = shadow_val[3:0];
      endcase
   end

   sseg_hex_dec u_dec (
      .nib (nib),
      .seg (seg_dec)
   );

`ifdef SSEG_LZB_EN
   // A digit is a leading zero when it and every digit left of it are zero;
   // a requested decimal point keeps it lit.
   logic [3:0] lz_off;
   always_comb begin
      lz_off    = '0;
      lz_off[1] = (shadow_val[15:4]  == '0) && !shadow_dp[1];
      lz_off[2] = (shadow_val[15:8]  == '0) && !shadow_dp[2];
      lz_off[3] = (shadow_val[15:12] == '0) && !shadow_dp[3];
   end
`endif

   always_comb begin
      an_nxt      = AN_OFF;
      an_nxt[dig] = 1'b0;
`ifdef SSEG_LZB_EN
      if (lz_off[dig]) an_nxt = AN_OFF;
`endif
      dp_nxt = ~shadow_dp[dig];
      if (bus.blank) begin
         an_nxt = AN_OFF;
         dp_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.an         <= AN_OFF;
         bus.seg        <= SEG_OFF;
         bus.dp         <= 1'b1;
         bus.frame_tick <= 1'b0;
      end else begin
         bus.an         <= an_nxt;
         bus.seg        <= seg_dec;
         bus.dp         <= dp_nxt;
         bus.frame_tick <= frame_end;
      end
   end

endmodule
